// File: rtl/coord_mem_arbiter_if.sv
// Bus bundle between the coordinate arbiter, its collector/engine requesters and the node RAM.
// slave = arbiter side, master = requesters + RAM side.
interface coord_mem_arbiter_if #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned COORD_W = 8
) ();
  logic                 clear;
  logic                 init_done;
  logic                 wr_req;
  logic [COORD_W-1:0]   wr_x;
  logic [COORD_W-1:0]   wr_y;
  logic                 wr_gnt;
  logic                 wr_err;
  logic                 rd_req;
  logic [ADDR_W-1:0]    rd_addr;
  logic                 rd_gnt;
  logic                 rd_valid;
  logic [COORD_W-1:0]   rd_x;
  logic [COORD_W-1:0]   rd_y;
  logic                 rd_oob;
  logic                 mem_we;
  logic                 mem_re;
  logic [ADDR_W-1:0]    mem_addr;
  logic [2*COORD_W-1:0] mem_wdata;
  logic [2*COORD_W-1:0] mem_rdata;
  logic [ADDR_W:0]      node_count;
  logic                 full;
  logic                 frozen;

  modport slave (
    input  clear, init_done, wr_req, wr_x, wr_y, rd_req, rd_addr, mem_rdata,
    output wr_gnt, wr_err, rd_gnt, rd_valid, rd_x, rd_y, rd_oob,
           mem_we, mem_re, mem_addr, mem_wdata, node_count, full, frozen
  );

  modport master (
    output clear, init_done, wr_req, wr_x, wr_y, rd_req, rd_addr, mem_rdata,
    input  wr_gnt, wr_err, rd_gnt, rd_valid, rd_x, rd_y, rd_oob,
           mem_we, mem_re, mem_addr, mem_wdata, node_count, full, frozen
  );
endinterface

// File: rtl/coord_mem_arbiter.sv
// Single-port node-coordinate RAM arbiter: sequential collector writes, engine reads, round-robin on ties.
// Optional seven-segment node-count status outputs under macro COORD_HEX_STATUS_EN.
module coord_mem_arbiter #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned COORD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
`ifdef COORD_HEX_STATUS_EN
  output logic [6:0]        hex0,
  output logic [6:0]        hex1,
`endif
  coord_mem_arbiter_if.slave bus
);
  localparam int unsigned      CNT_W    = ADDR_W + 1;
  localparam int unsigned      DATA_W   = 2 * COORD_W;
  localparam logic [CNT_W-1:0] CAPACITY = CNT_W'(1) << ADDR_W;

  typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;
  typedef enum logic {SIDE_WRITE = 1'b0, SIDE_READ = 1'b1} side_t;

  state_t             r_state, w_state_nxt;
  side_t              r_rr_last;
  logic [CNT_W-1:0]   r_count;
  logic               r_rd_valid;
  logic               r_rd_oob;
  logic [COORD_W-1:0] r_x_hold;
  logic [COORD_W-1:0] r_y_hold;

  logic               w_active, w_full, w_wr_elig, w_wr_want, w_rd_want;
  logic               w_contend, w_wr_gnt, w_rd_gnt, w_rd_inrange;
  logic [COORD_W-1:0] w_rd_x, w_rd_y;

  // Request qualification; reset low or clear suppresses every grant combinationally.
  assign w_active     = reset & ~bus.clear;
  assign w_full       = (r_count == CAPACITY);
  assign w_wr_elig    = (r_state == S_LOAD) & ~w_full;
  assign w_wr_want    = w_active & bus.wr_req & w_wr_elig;
  assign w_rd_want    = w_active & bus.rd_req;
  assign w_contend    = w_wr_want & w_rd_want;
  assign w_wr_gnt     = w_wr_want & (~w_rd_want | (r_rr_last == SIDE_READ));
  assign w_rd_gnt     = w_rd_want & ~w_wr_gnt;
  assign w_rd_inrange = ({1'b0, bus.rd_addr} < r_count);

  // Returned coordinates pass RAM data through on the valid cycle, otherwise hold.
  assign w_rd_x = r_rd_valid ? (r_rd_oob ? '0 : bus.mem_rdata[DATA_W-1:COORD_W]) : r_x_hold;
  assign w_rd_y = r_rd_valid ? (r_rd_oob ? '0 : bus.mem_rdata[COORD_W-1:0])      : r_y_hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_LOAD;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.clear)                                 w_state_nxt = S_LOAD;
    else if ((r_state == S_LOAD) && bus.init_done) w_state_nxt = S_RUN;
  end

  always_comb begin
    bus.wr_gnt     = w_wr_gnt;
    bus.rd_gnt     = w_rd_gnt;
    bus.wr_err     = w_active & bus.wr_req & ~w_wr_elig;
    bus.mem_we     = 1'b0;
    bus.mem_re     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.rd_valid   = r_rd_valid;
    bus.rd_oob     = r_rd_oob;
    bus.rd_x       = w_rd_x;
    bus.rd_y       = w_rd_y;
    bus.node_count = r_count;
    bus.full       = w_full;
    bus.frozen     = (r_state == S_RUN);
    if (w_wr_gnt) begin
      bus.mem_we    = 1'b1;
      bus.mem_addr  = r_count[ADDR_W-1:0];
      bus.mem_wdata = {bus.wr_x, bus.wr_y};
    end else if (w_rd_gnt && w_rd_inrange) begin
      bus.mem_re   = 1'b1;
      bus.mem_addr = bus.rd_addr;
    end
  end

  // Node count, round-robin history and read-return pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count    <= '0;
      r_rr_last  <= SIDE_READ;
      r_rd_valid <= 1'b0;
      r_rd_oob   <= 1'b0;
      r_x_hold   <= '0;
      r_y_hold   <= '0;
    end else begin
      r_rd_valid <= w_rd_gnt;
      r_rd_oob   <= w_rd_gnt & ~w_rd_inrange;
      if (r_rd_valid) begin
        r_x_hold <= w_rd_x;
        r_y_hold <= w_rd_y;
      end
      if (w_contend) r_rr_last <= w_wr_gnt ? SIDE_WRITE : SIDE_READ;
      if (bus.clear)     r_count <= '0;
      else if (w_wr_gnt) r_count <= r_count + CNT_W'(1);
    end
  end

`ifdef COORD_HEX_STATUS_EN
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
    endcase
  endfunction

  logic [7:0] w_cnt8;
  assign w_cnt8 = 8'(r_count);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex0 <= 7'b1000000;
      hex1 <= 7'b1000000;
    end else begin
      hex0 <= seg7(w_cnt8[3:0]);
      hex1 <= seg7(w_cnt8[7:4]);
    end
  end
`endif
endmodule

// File: doc/coord_mem_arbiter.md
Name: coord_mem_arbiter

Overview:
- Owns the single-port node-coordinate RAM and shares it between two requesters:
  - the coordinate collector, which writes (x,y) pairs during initialisation;
  - the pathfinding engine, which reads nodes during search.
- Assigns write addresses sequentially, tracks node count, and freezes the table once initialisation completes.
- Arbitrates simultaneous requests round-robin, so neither side starves.

Parameters:
- ADDR_W, 6, RAM address width; capacity = 2**ADDR_W nodes.
- COORD_W, 8, width of each x and y coordinate.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- clear  in  1  one-cycle pulse: discard table, return to LOAD
- init_done  in  1  level from collector; freezes table
- wr_req  in  1  collector write request, held until granted
- wr_x  in  COORD_W  x coordinate to store
- wr_y  in  COORD_W  y coordinate to store
- wr_gnt  out  1  write accepted this cycle
- wr_err  out  1  one-cycle pulse: write refused (full or frozen)
- rd_req  in  1  engine read request, held until granted
- rd_addr  in  ADDR_W  node index to read
- rd_gnt  out  1  read accepted this cycle
- rd_valid  out  1  read data valid (one cycle after rd_gnt)
- rd_x  out  COORD_W  returned x
- rd_y  out  COORD_W  returned y
- rd_oob  out  1  with rd_valid: rd_addr was >= node_count
- mem_we  out  1  RAM write enable
- mem_re  out  1  RAM read enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  2*COORD_W  {x,y} to RAM
- mem_rdata  in  2*COORD_W  {x,y} from RAM, valid one cycle after mem_re
- node_count  out  ADDR_W+1  number of stored nodes
- full  out  1  node_count == 2**ADDR_W
- frozen  out  1  state == RUN

Behaviour:
- Reset (reset low, async) values:
  - state LOAD; node_count 0; rr_last = READ, so WRITE wins the first tie.
  - All outputs 0.
- FSM:
  - LOAD -> RUN when init_done=1 (sampled on clk).
  - RUN -> LOAD on clear.
  - LOAD + clear: stays LOAD, node_count <= 0.
  - clear has priority over every other event in its cycle; no grant is issued that cycle.
- Grants are combinational in the request cycle; at most one of wr_gnt/rd_gnt per cycle.
- Write eligibility:
  - eligible only in LOAD with full=0;
  - otherwise wr_req yields wr_err for exactly one cycle per request cycle and no grant.
- Write grant:
  - mem_we=1, mem_addr=node_count[ADDR_W-1:0], mem_wdata={wr_x,wr_y};
  - node_count increments at the clock edge.
- Read eligibility: in either state.
- Read grant:
  - in range (rd_addr < node_count): mem_re=1, mem_addr=rd_addr; next cycle rd_valid=1 and {rd_x,rd_y}=mem_rdata.
  - out of range (rd_addr >= node_count): no RAM access; next cycle rd_valid=1, rd_oob=1, rd_x=rd_y=0.
- Contention (both eligible): grant the side not in rr_last, then update rr_last. The loser keeps its request asserted and wins the next cycle.
- rd_x/rd_y hold their last value while rd_valid=0.
- init_done rising in the same cycle as a write grant: the write completes and counts, then RUN.
- full asserts when the count reaches 2**ADDR_W; a further wr_req produces wr_err.
- node_count never wraps.
- Reset mid-operation: a pending rd_valid is dropped and the table is considered empty.

Optional Feature:
- Macro: COORD_HEX_STATUS_EN.
- When defined:
  - adds outputs hex0, hex1 [6:0], active-low seven-segment, bit6=g ... bit0=a;
  - hex0 shows node_count[3:0] in hex, hex1 shows node_count[7:4] (zero-extended);
  - registered, updated every clk; reset value = glyph "0" (7'b1000000).
- When undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset low, then 3 write pulses (1,2),(3,4),(5,6) with rd_req=0 -> mem_addr 0,1,2 with wr_gnt each; node_count=3; mem_wdata=16'h0102 on first.
- wr_req and rd_req held together for 4 cycles in LOAD -> grants W,R,W,R; node_count +2; rd_valid follows each rd_gnt by exactly 1 cycle.
- ADDR_W=2: 5 writes -> first 4 granted, full=1 after 4th, 5th gives wr_err pulse, node_count=4.
- init_done=1, then wr_req -> frozen=1, wr_err, no mem_we; rd_addr=1 returns stored (3,4); rd_addr=3 with node_count=3 -> rd_oob=1, rd_x=rd_y=0, mem_re=0.
- clear in RUN while rd_req and wr_req are asserted -> no grants that cycle; next cycle LOAD, node_count=0, write goes to address 0.
- Assert reset mid-read (cycle after rd_gnt) -> rd_valid stays 0, all outputs 0 immediately, without waiting for a clock edge.
